// File: rtl/spi_master_arbiter.sv
// Two-requester SPI master: round-robin arbitration, 41-bit mode-0 frames, read capture.
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority, where requester 0 always wins.
module spi_master_arbiter #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_wr,
  input  logic [6:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  input  logic        req1_valid,
  input  logic        req1_wr,
  input  logic [6:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        sclk,
  output logic        cs,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [5:0]  bit_reg, bit_next;
  logic        high_reg, high_next;
  logic [40:0] frame_reg, frame_next;
  logic [31:0] cap_reg, cap_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        id_reg, id_next;
  logic        wr_reg, wr_next;
  logic        sclk_reg, sclk_next;
  logic        cs_reg, cs_next;
  logic        mosi_reg, mosi_next;
  logic        done0_reg, done0_next;
  logic        done1_reg, done1_next;

  logic        grant_any;
  logic        pick1;
  logic        sel_wr;
  logic [6:0]  sel_addr;
  logic [31:0] sel_wdata;

  assign grant_any = !rst && (state_reg == ST_IDLE) && (req0_valid || req1_valid);

`ifdef SPI_ARB_FIXED_PRIO_EN
  assign pick1 = req1_valid && !req0_valid;
`else
  // last_reg = 1 when requester 1 won the previous grant; reset favours requester 0
  logic last_reg;
  assign pick1 = req1_valid && (!req0_valid || !last_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= 1'b1;
    end else if (grant_any) begin
      last_reg <= pick1;
    end
  end
`endif

  assign sel_wr    = pick1 ? req1_wr    : req0_wr;
  assign sel_addr  = pick1 ? req1_addr  : req0_addr;
  assign sel_wdata = pick1 ? req1_wdata : req0_wdata;

  assign req0_ready = grant_any && !pick1;
  assign req1_ready = grant_any && pick1;
  assign req0_done  = done0_reg;
  assign req1_done  = done1_reg;
  assign rdata      = rdata_reg;
  assign sclk       = sclk_reg;
  assign cs         = cs_reg;
  assign mosi       = mosi_reg;
  assign busy       = (state_reg != ST_IDLE) || grant_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      high_reg  <= 1'b0;
      frame_reg <= '0;
      cap_reg   <= '0;
      rdata_reg <= '0;
      id_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      sclk_reg  <= 1'b0;
      cs_reg    <= 1'b1;
      mosi_reg  <= 1'b0;
      done0_reg <= 1'b0;
      done1_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      high_reg  <= high_next;
      frame_reg <= frame_next;
      cap_reg   <= cap_next;
      rdata_reg <= rdata_next;
      id_reg    <= id_next;
      wr_reg    <= wr_next;
      sclk_reg  <= sclk_next;
      cs_reg    <= cs_next;
      mosi_reg  <= mosi_next;
      done0_reg <= done0_next;
      done1_reg <= done1_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    high_next  = high_reg;
    frame_next = frame_reg;
    cap_next   = cap_reg;
    rdata_next = rdata_reg;
    id_next    = id_reg;
    wr_next    = wr_reg;
    sclk_next  = sclk_reg;
    cs_next    = cs_reg;
    mosi_next  = mosi_reg;
    done0_next = 1'b0;
    done1_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (grant_any) begin
          state_next = ST_SETUP;
          cnt_next   = '0;
          id_next    = pick1;
          wr_next    = sel_wr;
          // mosi always mirrors frame_reg[40]; the frame is shifted left at each falling edge
          frame_next = {sel_wr, sel_addr, (sel_wr ? sel_wdata : 32'h0), 1'b0};
          mosi_next  = sel_wr;
          cs_next    = 1'b0;
          cap_next   = '0;
        end
      end

      ST_SETUP: begin
        if (cnt_reg == DIV_LAST) begin
          state_next = ST_SHIFT;
          cnt_next   = '0;
          bit_next   = 6'd1;
          high_next  = 1'b1;
          sclk_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      ST_SHIFT: begin
        if (cnt_reg != DIV_LAST) begin
          cnt_next = cnt_reg + 8'd1;
        end else begin
          cnt_next = '0;
          if (high_reg) begin
            high_next  = 1'b0;
            sclk_next  = 1'b0;
            // the first nine samples cover the command bits and carry no read data
            if (bit_reg >= 6'd10) begin
              cap_next = {cap_reg[30:0], miso};
            end
            mosi_next  = frame_reg[39];
            frame_next = {frame_reg[39:0], 1'b0};
          end else if (bit_reg == 6'd41) begin
            state_next = ST_HOLD;
          end else begin
            bit_next  = bit_reg + 6'd1;
            high_next = 1'b1;
            sclk_next = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (cnt_reg == DIV_LAST) begin
          state_next = ST_GAP;
          cnt_next   = '0;
          cs_next    = 1'b1;
          mosi_next  = 1'b0;
          done0_next = !id_reg;
          done1_next = id_reg;
          if (!wr_reg) begin
            rdata_next = cap_reg;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      ST_GAP: begin
        // the done cycle plus CS_GAP further clocks with cs high before IDLE
        if (cnt_reg == GAP_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
